dct_coef_sink: RTL and testbench

//  Receiving end of the 2-D DCT coefficient stream. Captures the 12-bit serial

---
 rtl/dct_coef_sink.sv | 206 ++++++++++++++++++++
 tb/tb_dct_coef_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_coef_sink.sv
// dct_coef_sink: captures row-major 8x8 DCT coefficient blocks into a ping-pong
// buffer and re-emits each block in JPEG zigzag (or raster) order over a
// valid/ready handshake. Blocks arriving with no free bank are dropped whole.
module dct_coef_sink #(
    parameter int DW     = 12,
    parameter bit ZIGZAG = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] coef_in,
    input  logic          coef_valid,
    output logic [DW-1:0] out_coef,
    output logic [5:0]    out_index,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    // Zigzag position k -> raster address within an 8x8 block.
    localparam logic [5:0] ZZ_TABLE [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Write front end
    logic [5:0]    r_wcnt;
    logic          r_wb;
    logic          r_drop;
    logic          r_overflow;
    logic          r_we;
    logic [6:0]    r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_wlast;
    logic          r_wlast_bank;

    // Bank state and buffer storage (bank select is the address MSB)
    logic [1:0]    r_full;
    logic [1:0]    w_full_next;
    logic [1:0]    w_set;
    logic [1:0]    w_clr;
    logic [DW-1:0] r_mem [128];
    logic [DW-1:0] r_ram_q;

    // Read side
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_rb;
    logic [5:0]    r_k;
    logic          r_valid;
    logic          w_rd_en;
    logic [5:0]    w_k_rd;
    logic [5:0]    w_rd_ofs;
    logic [6:0]    w_rd_addr;

    logic          w_accept;
    logic          w_release;
    logic          w_free_wb;
    logic          w_drop_now;
    logic          w_dropping;
    logic          w_write;

    assign w_accept   = r_valid & out_ready;
    assign w_release  = w_accept & (r_k == 6'd63);
    // A bank released this cycle counts as free for a block starting this cycle.
    assign w_free_wb  = w_release & (r_rb == r_wb);
    assign w_drop_now = coef_valid & (r_wcnt == 6'd0) & r_full[r_wb] & ~w_free_wb;
    assign w_dropping = (r_wcnt == 6'd0) ? w_drop_now : r_drop;
    assign w_write    = coef_valid & ~w_dropping;

    // Write counter, drop decision and one-stage registered write port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wcnt       <= 6'd0;
            r_wb         <= 1'b0;
            r_drop       <= 1'b0;
            r_overflow   <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= 7'd0;
            r_wdata      <= '0;
            r_wlast      <= 1'b0;
            r_wlast_bank <= 1'b0;
        end else begin
            r_overflow   <= w_drop_now;
            r_we         <= w_write;
            r_waddr      <= {r_wb, r_wcnt};
            r_wdata      <= coef_in;
            r_wlast      <= w_write & (r_wcnt == 6'd63);
            r_wlast_bank <= r_wb;
            if (coef_valid) begin
                r_wcnt <= r_wcnt + 6'd1;
                if (r_wcnt == 6'd0) begin
                    r_drop <= w_drop_now;
                end
                if ((r_wcnt == 6'd63) && !w_dropping) begin
                    r_wb <= ~r_wb;
                end
            end
        end
    end

    // Buffer write: plain array so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (r_we) begin
            r_mem[r_waddr] <= r_wdata;
        end
    end

    // Per-bank full flag: set when the last word lands, cleared on release.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign w_set[gi]       = r_wlast & (r_wlast_bank == gi[0]);
            assign w_clr[gi]       = w_release & (r_rb == gi[0]);
            assign w_full_next[gi] = w_set[gi] | (r_full[gi] & ~w_clr[gi]);
        end
    endgenerate

    // Full flags register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_next;
        end
    end

    // Read FSM next state and prefetch address.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_k_rd       = r_k;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rb]) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rd_en      = 1'b1;
                w_k_rd       = 6'd0;
                w_state_next = S_STREAM;
            end
            S_STREAM: begin
                if (w_accept) begin
                    if (r_k == 6'd63) begin
                        // Other bank ready (or completing now): skip IDLE.
                        w_state_next = w_full_next[~r_rb] ? S_LOAD : S_IDLE;
                    end else begin
                        w_rd_en = 1'b1;
                        w_k_rd  = r_k + 6'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_rd_ofs  = ZIGZAG ? ZZ_TABLE[w_k_rd] : w_k_rd;
    assign w_rd_addr = {r_rb, w_rd_ofs};

    // Synchronous buffer read; only advances on load or accept so data holds while stalled.
    always_ff @(posedge CLK) begin
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    // Read FSM state, read bank, position counter and valid flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_rb    <= 1'b0;
            r_k     <= 6'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_rd_en) begin
                r_k     <= w_k_rd;
                r_valid <= 1'b1;
            end else if (w_release) begin
                r_valid <= 1'b0;
                r_rb    <= ~r_rb;
            end
        end
    end

    // Outputs are forced to zero whenever nothing valid is presented.
    assign out_valid = r_valid;
    assign out_coef  = r_valid ? r_ram_q : '0;
    assign out_index = r_valid ? r_k : 6'd0;
    assign out_last  = r_valid & (r_k == 6'd63);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_dct_coef_sink.sv
// tb_dct_coef_sink: directed bench for dct_coef_sink; a zigzag instance and a
// raster instance share the same stimulus.
`timescale 1ns/1ps
module tb_dct_coef_sink;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] coef_in;
    logic        coef_valid;
    logic        out_ready;
    logic [11:0] out_coef;
    logic [5:0]  out_index;
    logic        out_valid;
    logic        out_last;
    logic        overflow;
    logic [11:0] rs_coef;
    logic [5:0]  rs_index;
    logic        rs_valid;
    logic        rs_last;
    logic        rs_overflow;

    always #5 CLK = ~CLK;

    dct_coef_sink #(.DW(12), .ZIGZAG(1'b1)) dut (
        .CLK(CLK), .RST(RST), .coef_in(coef_in), .coef_valid(coef_valid),
        .out_coef(out_coef), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .overflow(overflow)
    );

    dct_coef_sink #(.DW(12), .ZIGZAG(1'b0)) dut_r (
        .CLK(CLK), .RST(RST), .coef_in(coef_in), .coef_valid(coef_valid),
        .out_coef(rs_coef), .out_index(rs_index), .out_valid(rs_valid),
        .out_ready(out_ready), .out_last(rs_last), .overflow(rs_overflow)
    );

    logic [5:0] zz [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [11:0] blk [3][64];
    logic [11:0] q_coef [$];
    logic [5:0]  q_idx [$];
    logic        q_last [$];
    int          q_cyc [$];
    logic [11:0] qr_coef [$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rise_cyc = -1;
    int          ovf_cnt = 0;
    int          ovf_cyc = -1;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_coef = '0;
    logic [5:0]  prev_idx = '0;
    logic        prev_last = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records handshakes, overflow pulses and checks stall hold.
    always @(negedge CLK) begin
        if (!RST) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_coef", {20'd0, out_coef}, {20'd0, prev_coef});
                check("stall_idx", {26'd0, out_index}, {26'd0, prev_idx});
                check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                q_coef.push_back(out_coef);
                q_idx.push_back(out_index);
                q_last.push_back(out_last);
                q_cyc.push_back(cyc);
            end
            if (rs_valid && out_ready) qr_coef.push_back(rs_coef);
            if (overflow) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
            prev_valid = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_coef  = out_coef;
            prev_idx   = out_index;
            prev_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        coef_valid = 1'b0;
        coef_in = '0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        q_coef.delete();
        q_idx.delete();
        q_last.delete();
        q_cyc.delete();
        qr_coef.delete();
        rise_cyc = -1;
        ovf_cnt = 0;
        ovf_cyc = -1;
    endtask

    // Drive one 64-word block; report capture edges of words 0 and 63.
    task automatic send(input int b, input int gap, output int cap_first, output int cap_last);
        for (int i = 0; i < 64; i++) begin
            coef_in = blk[b][i];
            coef_valid = 1'b1;
            if (i == 0) cap_first = cyc + 1;
            if (i == 63) cap_last = cyc + 1;
            tick();
        end
        coef_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int t = 0;
        while (q_coef.size() < n && t < budget) begin
            tick();
            t++;
        end
        check("out_count", q_coef.size(), n);
    endtask

    task automatic check_block(input int qbase, input int b, input string tag);
        for (int k = 0; k < 64; k++) begin
            check($sformatf("%s_coef_k%0d", tag, k), {20'd0, q_coef[qbase+k]}, {20'd0, blk[b][zz[k]]});
            check($sformatf("%s_idx_k%0d", tag, k), {26'd0, q_idx[qbase+k]}, k);
            check($sformatf("%s_last_k%0d", tag, k), {31'd0, q_last[qbase+k]}, (k == 63) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int f0, l0, f1, l1, f2, l2;
        RST = 1'b0;
        coef_valid = 1'b0;
        coef_in = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_coef", {20'd0, out_coef}, 32'd0);
        check("rst_index", {26'd0, out_index}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Test 1 / 6: single block 0..63, ready held high.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk[0][i] = 12'(i);
        send(0, 0, f0, l0);
        wait_outputs(64, 300);
        check("t1_latency", rise_cyc - l0, 3);
        check_block(0, 0, "t1");
        check("t1_contig", q_cyc[63] - q_cyc[0], 63);
        check("t1_ovf", ovf_cnt, 0);
        check("t6_count", qr_coef.size(), 64);
        for (int k = 0; k < 64; k++) check($sformatf("t6_k%0d", k), {20'd0, qr_coef[k]}, k);

        // Test 2: three blocks, one idle input cycle between them, ready high.
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) blk[b][i] = 12'(256 * (b + 1) + i);
        send(0, 1, f0, l0);
        send(1, 1, f1, l1);
        send(2, 0, f2, l2);
        wait_outputs(192, 500);
        check_block(0, 0, "t2b0");
        check_block(64, 1, "t2b1");
        check_block(128, 2, "t2b2");
        check("t2_gap1", q_cyc[64] - q_cyc[63], 2);
        check("t2_gap2", q_cyc[128] - q_cyc[127], 2);
        check("t2_ovf", ovf_cnt, 0);

        // Test 3: ready low while three blocks arrive back-to-back.
        do_reset();
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) blk[b][i] = 12'(12'h400 + 64 * b + i);
        send(0, 0, f0, l0);
        send(1, 0, f1, l1);
        send(2, 0, f2, l2);
        repeat (5) tick();
        check("t3_ovf_count", ovf_cnt, 1);
        check("t3_ovf_cycle", ovf_cyc, f2);
        check("t3_stalled", q_coef.size(), 0);
        out_ready = 1'b1;
        wait_outputs(128, 400);
        repeat (80) tick();
        check("t3_total", q_coef.size(), 128);
        check_block(0, 0, "t3b0");
        check_block(64, 1, "t3b1");

        // Test 4: ready toggling 1010... during input and readout.
        do_reset();
        for (int i = 0; i < 64; i++) blk[0][i] = 12'(i);
        for (int t = 0; t < 600 && q_coef.size() < 64; t++) begin
            out_ready = (t % 2 == 0);
            coef_valid = (t < 64);
            coef_in = (t < 64) ? blk[0][t] : 12'd0;
            tick();
        end
        coef_valid = 1'b0;
        out_ready = 1'b1;
        check("t4_count", q_coef.size(), 64);
        check_block(0, 0, "t4");

        // Test 5: reset after 30 coefficients, then a fresh block with extremes.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            coef_in = 12'(12'h3C0 + i);
            coef_valid = 1'b1;
            tick();
        end
        RST = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_ovf", {31'd0, overflow}, 32'd0);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk[0][i] = 12'(12'hA00 + i);
        blk[0][1] = 12'h800;
        blk[0][8] = 12'h7FF;
        send(0, 0, f0, l0);
        wait_outputs(64, 300);
        check("t5_min", {20'd0, q_coef[1]}, 32'h800);
        check("t5_max", {20'd0, q_coef[2]}, 32'h7FF);
        check_block(0, 0, "t5");
        repeat (80) tick();
        check("t5_total", q_coef.size(), 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
